data_mem_controller: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_request_picker.sv | 31 +++
 rtl/data_mem_controller.sv | 195 +++++++++++++++++++
 tb/tb_data_mem_controller.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data/program memory controller: channel FSM states
// and the consumer-index width helper.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        READ_WAITING  = 2'd1,
        WRITE_WAITING = 2'd2,
        RELAYING      = 2'd3
    } channel_state_t;

    // Width of a consumer index; never collapses to zero bits.
    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_request_picker.sv
// Lowest-index request selection for one channel; consumers in the exclusion
// mask are already being served or were claimed by a lower channel this cycle.
module mem_request_picker
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CONSUMERS = 8,
    parameter int IDX_BITS      = index_bits(NUM_CONSUMERS)
) (
    input  logic [NUM_CONSUMERS-1:0] read_valid,
    input  logic [NUM_CONSUMERS-1:0] write_valid,
    input  logic [NUM_CONSUMERS-1:0] exclude,
    output logic                     found,
    output logic [IDX_BITS-1:0]      index,
    output logic                     is_read
);

    // Scanning downward lets the lowest eligible index overwrite the rest.
    always_comb begin
        found   = 1'b0;
        index   = '0;
        is_read = 1'b0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            if (!exclude[i] && (read_valid[i] || write_valid[i])) begin
                found   = 1'b1;
                index   = IDX_BITS'(i);
                is_read = read_valid[i];
            end
        end
    end

endmodule

// File: rtl/data_mem_controller.sv
// Arbitrates per-consumer load/store requests onto NUM_CHANNELS memory channels.
// With WRITE_ENABLE=0 the write side is tied off and it serves program memory.
module data_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
    output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

    localparam int IDX_BITS = index_bits(NUM_CONSUMERS);

    channel_state_t                     state [NUM_CHANNELS];
    channel_state_t                     state_next [NUM_CHANNELS];
    logic [IDX_BITS-1:0]                current_consumer [NUM_CHANNELS];
    logic [IDX_BITS-1:0]                current_consumer_next [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]            is_read_q, is_read_next;
    logic [NUM_CONSUMERS-1:0]           serving, serving_next;

    logic [NUM_CHANNELS-1:0]                 mrv_q, mrv_next;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_q, mra_next;
    logic [NUM_CHANNELS-1:0]                 mwv_q, mwv_next;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mwa_q, mwa_next;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_q, mwd_next;
    logic [NUM_CONSUMERS-1:0]                crr_q, crr_next;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] crd_q, crd_next;
    logic [NUM_CONSUMERS-1:0]                cwr_q, cwr_next;

    logic [NUM_CONSUMERS-1:0]                write_req;
    logic [NUM_CHANNELS-1:0]                 pick_grant;
    logic [NUM_CHANNELS-1:0]                 pick_is_read;
    logic [NUM_CHANNELS-1:0][IDX_BITS-1:0]   pick_index;

    assign write_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;

    // Each channel sees the serving mask plus every consumer claimed by a
    // lower-numbered channel in this same cycle.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        logic [NUM_CONSUMERS-1:0] mask_in;
        logic                     found;
        logic                     grant;
        logic                     is_read;
        logic [IDX_BITS-1:0]      index;

        if (c == 0) begin : g_first
            assign mask_in = serving;
        end else begin : g_chain
            assign mask_in = g_ch[c-1].grant
                ? (g_ch[c-1].mask_in | (NUM_CONSUMERS'(1) << g_ch[c-1].index))
                : g_ch[c-1].mask_in;
        end

        mem_request_picker #(
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .IDX_BITS      (IDX_BITS)
        ) u_picker (
            .read_valid  (consumer_read_valid),
            .write_valid (write_req),
            .exclude     (mask_in),
            .found       (found),
            .index       (index),
            .is_read     (is_read)
        );

        assign grant           = found && (state[c] == IDLE);
        assign pick_grant[c]   = grant;
        assign pick_is_read[c] = is_read;
        assign pick_index[c]   = index;
    end

    always_comb begin
        state_next            = state;
        current_consumer_next = current_consumer;
        is_read_next          = is_read_q;
        serving_next          = serving;
        mrv_next              = mrv_q;
        mra_next              = mra_q;
        mwv_next              = mwv_q;
        mwa_next              = mwa_q;
        mwd_next              = mwd_q;
        crr_next              = crr_q;
        crd_next              = crd_q;
        cwr_next              = cwr_q;

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            case (state[c])
                IDLE: begin
                    if (pick_grant[c]) begin
                        serving_next[pick_index[c]] = 1'b1;
                        current_consumer_next[c]    = pick_index[c];
                        is_read_next[c]             = pick_is_read[c];
                        if (pick_is_read[c]) begin
                            mrv_next[c]   = 1'b1;
                            mra_next[c]   = consumer_read_address[pick_index[c]];
                            state_next[c] = READ_WAITING;
                        end else begin
                            mwv_next[c]   = 1'b1;
                            mwa_next[c]   = consumer_write_address[pick_index[c]];
                            mwd_next[c]   = consumer_write_data[pick_index[c]];
                            state_next[c] = WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready[c]) begin
                        mrv_next[c]                      = 1'b0;
                        crd_next[current_consumer[c]]    = mem_read_data[c];
                        crr_next[current_consumer[c]]    = 1'b1;
                        state_next[c]                    = RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready[c]) begin
                        mwv_next[c]                      = 1'b0;
                        cwr_next[current_consumer[c]]    = 1'b1;
                        state_next[c]                    = RELAYING;
                    end
                end
                RELAYING: begin
                    if (is_read_q[c] ? !consumer_read_valid[current_consumer[c]]
                                     : !consumer_write_valid[current_consumer[c]]) begin
                        if (is_read_q[c]) crr_next[current_consumer[c]] = 1'b0;
                        else              cwr_next[current_consumer[c]] = 1'b0;
                        serving_next[current_consumer[c]] = 1'b0;
                        state_next[c]                     = IDLE;
                    end
                end
                default: state_next[c] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state[c]            <= IDLE;
                current_consumer[c] <= '0;
            end
            is_read_q <= '0;
            serving   <= '0;
            mrv_q     <= '0;
            mra_q     <= '0;
            mwv_q     <= '0;
            mwa_q     <= '0;
            mwd_q     <= '0;
            crr_q     <= '0;
            crd_q     <= '0;
            cwr_q     <= '0;
        end else begin
            state            <= state_next;
            current_consumer <= current_consumer_next;
            is_read_q        <= is_read_next;
            serving          <= serving_next;
            mrv_q            <= mrv_next;
            mra_q            <= mra_next;
            mwv_q            <= mwv_next;
            mwa_q            <= mwa_next;
            mwd_q            <= mwd_next;
            crr_q            <= crr_next;
            crd_q            <= crd_next;
            cwr_q            <= cwr_next;
        end
    end

    assign mem_read_valid       = mrv_q;
    assign mem_read_address     = mra_q;
    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
    assign mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
    assign mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;
    assign consumer_write_ready = (WRITE_ENABLE != 0) ? cwr_q : '0;

endmodule

// File: tb/tb_data_mem_controller.sv
// Bench for data_mem_controller: a default 8x4 data-memory instance and a
// 2x1 read-only program-memory instance, each with a behavioural memory.
module tb_data_mem_controller;

    localparam int NC  = 8;
    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0]        c_rv, c_wv, c_rr, c_wr;
    logic [NC-1:0][7:0]   c_ra, c_wa, c_wd, c_rd;
    logic [NCH-1:0]       m_rv, m_wv, m_rr, m_wr;
    logic [NCH-1:0][7:0]  m_ra, m_wa, m_wd, m_rdata;
    logic [NCH-1:0]       mdl_rr = '0, mdl_wr = '0, inj_rr = '0;

    assign m_rr = mdl_rr | inj_rr;
    assign m_wr = mdl_wr;

    data_mem_controller dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
        .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
        .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
        .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
        .mem_read_valid(m_rv), .mem_read_address(m_ra),
        .mem_read_ready(m_rr), .mem_read_data(m_rdata),
        .mem_write_valid(m_wv), .mem_write_address(m_wa),
        .mem_write_data(m_wd), .mem_write_ready(m_wr)
    );

    logic [1:0]       p_rv, p_wv, p_rr, p_wr;
    logic [1:0][7:0]  p_ra, p_wa, p_wd, p_rd;
    logic [0:0]       p_mrv, p_mwv, p_mwr;
    logic [0:0]       p_mrr = '0;
    logic [0:0][7:0]  p_mra, p_mwa, p_mwd;
    logic [0:0][7:0]  p_mrd = '0;

    assign p_mwr = 1'b1;

    data_mem_controller #(
        .NUM_CONSUMERS(2), .NUM_CHANNELS(1), .WRITE_ENABLE(0)
    ) dut_p (
        .clk(clk), .reset(reset),
        .consumer_read_valid(p_rv), .consumer_read_address(p_ra),
        .consumer_read_ready(p_rr), .consumer_read_data(p_rd),
        .consumer_write_valid(p_wv), .consumer_write_address(p_wa),
        .consumer_write_data(p_wd), .consumer_write_ready(p_wr),
        .mem_read_valid(p_mrv), .mem_read_address(p_mra),
        .mem_read_ready(p_mrr), .mem_read_data(p_mrd),
        .mem_write_valid(p_mwv), .mem_write_address(p_mwa),
        .mem_write_data(p_mwd), .mem_write_ready(p_mwr)
    );

    // Behavioural data memory: contents a+1 at start, fixed or random latency.
    logic [7:0] mem_array [256];
    bit         mem_init = 1'b0;
    bit         pre_en = 1'b0;
    logic [7:0] pre_addr = '0, pre_val = '0;
    int         mem_lat = 0;
    bit         rand_lat = 1'b0;
    int         rcnt [NCH], wcnt [NCH], rlat [NCH], wlat [NCH];
    bit         rstarted [NCH], wstarted [NCH];

    always @(negedge clk) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) mem_array[a] = 8'(a + 1);
            mem_init = 1'b1;
        end
        if (pre_en) mem_array[pre_addr] = pre_val;
        for (int c = 0; c < NCH; c++) begin
            if (mdl_rr[c]) begin
                mdl_rr[c] = 1'b0;
                rstarted[c] = 1'b0;
            end else if (m_rv[c]) begin
                if (!rstarted[c]) begin
                    rstarted[c] = 1'b1;
                    rcnt[c] = 0;
                    rlat[c] = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (rcnt[c] == rlat[c]) begin
                    mdl_rr[c] = 1'b1;
                    m_rdata[c] = mem_array[m_ra[c]];
                end else rcnt[c]++;
            end else rstarted[c] = 1'b0;

            if (mdl_wr[c]) begin
                mdl_wr[c] = 1'b0;
                wstarted[c] = 1'b0;
            end else if (m_wv[c]) begin
                if (!wstarted[c]) begin
                    wstarted[c] = 1'b1;
                    wcnt[c] = 0;
                    wlat[c] = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
                end
                if (wcnt[c] == wlat[c]) begin
                    mdl_wr[c] = 1'b1;
                    mem_array[m_wa[c]] = m_wd[c];
                end else wcnt[c]++;
            end else wstarted[c] = 1'b0;
        end
    end

    // Program memory: zero extra latency, data = address ^ 0xC3.
    always @(negedge clk) begin
        if (p_mrr[0]) p_mrr[0] = 1'b0;
        else if (p_mrv[0]) begin
            p_mrr[0] = 1'b1;
            p_mrd[0] = p_mra[0] ^ 8'hC3;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit         is_write;
        int         cons;
        logic [7:0] addr;
        logic [7:0] data;
        int         lat;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, actual running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int gch [NC];
        int gcyc [NC];
        bit done [NC];
        logic [NCH-1:0] prev_rv;
        logic [7:0] order [4];
        int n_order, cnt;
        bit dup, bad, early_wr, seen;
        logic [7:0] model_mem [256];
        bit busy [NC], is_wr [NC];
        logic [7:0] raddr [NC], rwdata [NC];
        int left [NC], waitc [NC];
        bit all_idle, timed_out;
        logic p_prev;

        vecs[0] = '{1'b0, 3, 8'h05, 8'h2A, 2};
        vecs[1] = '{1'b1, 5, 8'h0A, 8'h77, 0};
        vecs[2] = '{1'b0, 0, 8'h7F, 8'h81, 0};
        vecs[3] = '{1'b0, 7, 8'h00, 8'hFF, 1};
        vecs[4] = '{1'b1, 1, 8'h33, 8'h00, 3};
        vecs[5] = '{1'b1, 6, 8'h2F, 8'hC4, 1};

        reset = 1'b1;
        c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
        p_rv = '0; p_wv = '0; p_ra = '0; p_wa = '0; p_wd = '0;
        repeat (3) @(negedge clk);
        check("reset_mem_read_valid", m_rv, 0);
        check("reset_mem_write_valid", m_wv, 0);
        check("reset_consumer_read_ready", c_rr, 0);
        check("reset_consumer_write_ready", c_wr, 0);
        check("reset_serving", dut.serving, 0);
        check("reset_prog_read_valid", p_mrv, 0);
        reset = 1'b0;

        // Eight simultaneous reads of address i; memory holds i+1.
        @(negedge clk);
        mem_lat = 0;
        for (int i = 0; i < NC; i++) begin
            c_ra[i] = 8'(i); gch[i] = -1; gcyc[i] = -1; done[i] = 1'b0;
        end
        c_rv = '1;
        prev_rv = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            dup = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                if (m_rv[c] && !prev_rv[c] && m_ra[c] < 8) begin
                    gch[m_ra[c]] = c; gcyc[m_ra[c]] = cyc;
                end
                for (int d = c + 1; d < NCH; d++)
                    if (m_rv[c] && m_rv[d] && m_ra[c] == m_ra[d]) dup = 1'b1;
            end
            check("wave_no_dup", dup, 0);
            for (int i = 0; i < NC; i++) begin
                if (c_rr[i] && c_rv[i]) begin
                    check("wave_data", c_rd[i], i + 1);
                    c_rv[i] = 1'b0; done[i] = 1'b1;
                end
            end
            prev_rv = m_rv;
            if (c_rv == 0 && m_rv == 0 && c_rr == 0) break;
        end
        for (int i = 0; i < NC; i++) begin
            check("wave_done", done[i], 1);
            check("wave_channel", gch[i], i % NCH);
            check("wave_cycle", gcyc[i], (i < NCH) ? 1 : 4);
        end

        // Single-transaction table.
        foreach (vecs[r]) begin
            @(negedge clk);
            mem_lat = vecs[r].lat;
            if (vecs[r].is_write) begin
                c_wa[vecs[r].cons] = vecs[r].addr;
                c_wd[vecs[r].cons] = vecs[r].data;
                c_wv[vecs[r].cons] = 1'b1;
            end else begin
                pre_en = 1'b1; pre_addr = vecs[r].addr; pre_val = vecs[r].data;
                c_ra[vecs[r].cons] = vecs[r].addr;
                c_rv[vecs[r].cons] = 1'b1;
            end
            @(negedge clk);
            if (vecs[r].is_write) begin
                check("row_write_issue", m_wv, 4'b0001);
                check("row_write_addr", m_wa[0], vecs[r].addr);
                check("row_write_data", m_wd[0], vecs[r].data);
            end else begin
                check("row_read_issue", m_rv, 4'b0001);
                check("row_read_addr", m_ra[0], vecs[r].addr);
            end
            cnt = 0;
            while (!(vecs[r].is_write ? c_wr[vecs[r].cons] : c_rr[vecs[r].cons]) && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check("row_latency", cnt, vecs[r].lat + 1);
            if (vecs[r].is_write) begin
                check("row_mem_written", mem_array[vecs[r].addr], vecs[r].data);
                c_wv[vecs[r].cons] = 1'b0;
            end else begin
                check("row_read_data", c_rd[vecs[r].cons], vecs[r].data);
                c_rv[vecs[r].cons] = 1'b0;
            end
            pre_en = 1'b0;
            @(negedge clk);
            check("row_ready_drop", c_rr | c_wr, 0);
            if (!vecs[r].is_write)
                check("row_data_hold", c_rd[vecs[r].cons], vecs[r].data);
            check("row_serving_clear", dut.serving, 0);
        end

        // Stray read ready on an idle channel must be ignored.
        @(negedge clk);
        #1 inj_rr = 4'b0100;
        @(negedge clk);
        inj_rr = '0;
        @(negedge clk);
        check("stray_ready_ignored", c_rr, 0);
        check("stray_ready_serving", dut.serving, 0);

        // Consumer 2 with read and write valid together: read first.
        mem_lat = 1;
        c_ra[2] = 8'h40; c_wa[2] = 8'h41; c_wd[2] = 8'h99;
        c_rv[2] = 1'b1; c_wv[2] = 1'b1;
        @(negedge clk);
        check("rw_read_first", m_rv, 4'b0001);
        check("rw_no_write_yet", m_wv, 0);
        check("rw_read_addr", m_ra[0], 8'h40);
        early_wr = 1'b0;
        cnt = 0;
        while (!c_rr[2] && cnt < 20) begin
            @(negedge clk);
            if (m_wv != 0) early_wr = 1'b1;
            cnt++;
        end
        check("rw_read_ready", c_rr[2], 1);
        check("rw_read_data", c_rd[2], 8'h41);
        c_rv[2] = 1'b0;
        cnt = 0;
        seen = 1'b0;
        while (cnt < 20 && !seen) begin
            @(negedge clk);
            if (m_wv != 0) seen = 1'b1;
            cnt++;
        end
        check("rw_write_before_close", early_wr, 0);
        check("rw_write_issue", m_wv, 4'b0001);
        check("rw_write_wait", cnt, 2);
        check("rw_write_addr", m_wa[0], 8'h41);
        check("rw_write_data", m_wd[0], 8'h99);
        cnt = 0;
        while (!c_wr[2] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rw_write_ready", c_wr[2], 1);
        c_wv[2] = 1'b0;
        @(negedge clk);

        // Reset while channels 0-1 are waiting on a memory that never answers.
        mem_lat = 100;
        c_ra[0] = 8'h50; c_ra[1] = 8'h51;
        c_rv[1:0] = 2'b11;
        @(negedge clk);
        check("rst_mid_busy", m_rv, 4'b0011);
        @(negedge clk);
        reset = 1'b1;
        c_rv = '0;
        @(negedge clk);
        check("rst_mid_mem_read_valid", m_rv, 0);
        check("rst_mid_mem_read_addr", m_ra, 0);
        check("rst_mid_mem_write_valid", m_wv, 0);
        check("rst_mid_mem_write_addr", m_wa, 0);
        check("rst_mid_mem_write_data", m_wd, 0);
        check("rst_mid_consumer_ready", c_rr | c_wr, 0);
        check("rst_mid_consumer_data_lo", c_rd[3:0], 0);
        check("rst_mid_consumer_data_hi", c_rd[7:4], 0);
        check("rst_mid_serving", dut.serving, 0);
        reset = 1'b0;
        mem_lat = 1;
        @(negedge clk);
        c_ra[6] = 8'h60; c_rv[6] = 1'b1;
        @(negedge clk);
        check("rst_fresh_issue", m_rv, 4'b0001);
        check("rst_fresh_addr", m_ra[0], 8'h60);
        cnt = 0;
        while (!c_rr[6] && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_fresh_data", c_rd[6], 8'h61);
        c_rv[6] = 1'b0;
        @(negedge clk);

        // Program-memory instance: writes ignored, reads serialized in index order.
        p_ra[0] = 8'h10; p_ra[1] = 8'h20;
        p_wa[0] = 8'hAA; p_wa[1] = 8'hBB; p_wd[0] = 8'h5A; p_wd[1] = 8'hA5;
        p_rv = 2'b11; p_wv = 2'b11;
        n_order = 0; bad = 1'b0; p_prev = 1'b0;
        done[0] = 1'b0; done[1] = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (p_mwv != 0 || p_mwa != 0 || p_mwd != 0 || p_wr != 0) bad = 1'b1;
            if (p_mrv[0] && !p_prev && n_order < 4) begin
                order[n_order] = p_mra[0];
                n_order++;
            end
            p_prev = p_mrv[0];
            for (int k = 0; k < 2; k++) begin
                if (p_rr[k] && p_rv[k]) begin
                    check("prog_read_data", p_rd[k], p_ra[k] ^ 8'hC3);
                    p_rv[k] = 1'b0; p_wv[k] = 1'b0; done[k] = 1'b1;
                end
            end
            if (done[0] && done[1]) break;
        end
        check("prog_write_side_zero", bad, 0);
        check("prog_both_done", {done[0], done[1]}, 2'b11);
        check("prog_grant_count", n_order, 2);
        check("prog_order_first", order[0], 8'h10);
        check("prog_order_second", order[1], 8'h20);

        // Random traffic; consumer i only touches addresses {1, xxxx, i}.
        @(negedge clk);
        rand_lat = 1'b1;
        for (int a = 128; a < 256; a++) model_mem[a] = 8'(a + 1);
        for (int i = 0; i < NC; i++) begin
            busy[i] = 1'b0; left[i] = 20; waitc[i] = 0; is_wr[i] = 1'b0;
            raddr[i] = '0; rwdata[i] = '0;
        end
        timed_out = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            dup = 1'b0;
            for (int c = 0; c < NCH; c++)
                for (int d = 0; d < NCH; d++)
                    if (c != d && (m_rv[c] || m_wv[c]) && (m_rv[d] || m_wv[d])) begin
                        if ((m_rv[c] ? m_ra[c][2:0] : m_wa[c][2:0]) ==
                            (m_rv[d] ? m_ra[d][2:0] : m_wa[d][2:0])) dup = 1'b1;
                    end
            check("rand_no_dup", dup, 0);
            bad = 1'b0;
            for (int i = 0; i < NC; i++) begin
                if (c_rr[i] && !(busy[i] && !is_wr[i])) bad = 1'b1;
                if (c_wr[i] && !(busy[i] && is_wr[i])) bad = 1'b1;
            end
            check("rand_spurious_ready", bad, 0);
            all_idle = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (busy[i]) begin
                    if (!is_wr[i] && c_rr[i]) begin
                        check("rand_read_data", c_rd[i], model_mem[raddr[i]]);
                        c_rv[i] = 1'b0; busy[i] = 1'b0;
                    end else if (is_wr[i] && c_wr[i]) begin
                        model_mem[raddr[i]] = rwdata[i];
                        c_wv[i] = 1'b0; busy[i] = 1'b0;
                    end else begin
                        waitc[i]++;
                        if (waitc[i] > 200) timed_out = 1'b1;
                    end
                end else if (left[i] > 0 && $urandom_range(0, 2) == 0) begin
                    busy[i] = 1'b1; left[i]--; waitc[i] = 0;
                    is_wr[i] = 1'($urandom_range(0, 1));
                    raddr[i] = {1'b1, 4'($urandom_range(0, 15)), 3'(i)};
                    rwdata[i] = 8'($urandom);
                    if (is_wr[i]) begin
                        c_wa[i] = raddr[i]; c_wd[i] = rwdata[i]; c_wv[i] = 1'b1;
                    end else begin
                        c_ra[i] = raddr[i]; c_rv[i] = 1'b1;
                    end
                end
                if (busy[i] || left[i] > 0) all_idle = 1'b0;
            end
            if (all_idle || timed_out) break;
        end
        check("rand_timeout", timed_out, 0);
        check("rand_all_complete", all_idle, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
